// File: rtl/vp_pkg.sv
// Shared types for the VP decoder slice.
//   vp_addr_t  : packed 3x7-bit address carried by each entry
//   vp_data_t  : signed 16-bit weight / activation
//   vp_entry_t : one buffer entry {addr, w, ia}
//   vp_group_t : one complete 3-entry left or right buffer
package vp_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 16;
  localparam int VP_ENTRIES = 3;

  typedef logic [2:0][ADDR_W-1:0] vp_addr_t;
  typedef logic signed [DATA_W-1:0] vp_data_t;

  typedef struct packed {
    vp_addr_t addr;
    vp_data_t w;
    vp_data_t ia;
  } vp_entry_t;

  typedef vp_entry_t [VP_ENTRIES-1:0] vp_group_t;

endpackage

// File: rtl/vp_group_fifo.sv
// Group queue: GRP_DEPTH slots of vp_group_t with two push ports and one pop.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push_r, grp_r  : right-group push request and data (higher priority)
//   push_l, grp_l  : left-group push request and data
//   pop            : remove head group (caller guarantees queue not empty)
//   head           : current head group
//   acc_r, acc_l   : push request accepted this cycle (a request without accept is a drop)
//   empty, count   : occupancy
module vp_group_fifo
  import vp_pkg::*;
#(
  parameter int GRP_DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       push_r,
  input  vp_group_t                  grp_r,
  input  logic                       push_l,
  input  vp_group_t                  grp_l,
  input  logic                       pop,
  output vp_group_t                  head,
  output logic                       acc_r,
  output logic                       acc_l,
  output logic                       empty,
  output logic [$clog2(GRP_DEPTH):0] count
);

  localparam int PW = $clog2(GRP_DEPTH);

  vp_group_t       mem [GRP_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr_l;
  logic [PW:0]     free_slots;

  // A slot vacated by a same-cycle pop is usable, so a full queue can still accept.
  assign free_slots = (PW+1)'(GRP_DEPTH) - count + (PW+1)'(pop);
  assign acc_r      = push_r && (free_slots != '0);
  assign acc_l      = push_l && (free_slots > (acc_r ? (PW+1)'(1) : (PW+1)'(0)));
  assign wr_ptr_l   = acc_r ? wr_ptr + PW'(1) : wr_ptr;
  assign empty      = (count == '0);
  assign head       = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (acc_r) mem[wr_ptr]   <= grp_r;
    if (acc_l) mem[wr_ptr_l] <= grp_l;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(acc_r) + PW'(acc_l);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + (PW+1)'(acc_r) + (PW+1)'(acc_l) - (PW+1)'(pop);
    end
  end

endmodule

// File: rtl/vp_decoder.sv
// VP decoder: captures ping-pong buffer groups from the VP encoder, queues them,
// serializes entries one per cycle, and streams (addr, w*ia) to the accumulator.
//   i_clk, i_rst_n             : clock, asynchronous active-low reset
//   i_right_ready/i_left_ready : one-cycle strobes, buffer contents valid that cycle
//   i_addr_*/i_w_*/i_ia_*      : 3-entry buffer contents
//   i_finish                   : encoder column finished (rising edge used)
//   i_out_ready                : downstream accepts o_addr/o_psum
//   o_valid/o_addr/o_psum      : product stream (zero-weight entries dropped)
//   o_done                     : one-cycle pulse once finish seen and all queued work emitted
//   o_overflow                 : sticky, a group was dropped because the queue was full
module vp_decoder
  import vp_pkg::*;
#(
  parameter int GRP_DEPTH = 4,
  parameter int PROD_W    = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_right_ready,
  input  logic                           i_left_ready,
  input  vp_addr_t [VP_ENTRIES-1:0]      i_addr_right,
  input  vp_data_t [VP_ENTRIES-1:0]      i_w_right,
  input  vp_data_t [VP_ENTRIES-1:0]      i_ia_right,
  input  vp_addr_t [VP_ENTRIES-1:0]      i_addr_left,
  input  vp_data_t [VP_ENTRIES-1:0]      i_w_left,
  input  vp_data_t [VP_ENTRIES-1:0]      i_ia_left,
  input  logic                           i_finish,
  input  logic                           i_out_ready,
  output logic                           o_valid,
  output vp_addr_t                       o_addr,
  output logic signed [PROD_W-1:0]       o_psum,
  output logic                           o_done,
  output logic                           o_overflow
);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  localparam int CW = $clog2(GRP_DEPTH) + 1;

  function automatic logic signed [PROD_W-1:0] mul_full(input vp_data_t w, input vp_data_t ia);
    return PROD_W'(w) * PROD_W'(ia);
  endfunction

  state_t          state;
  logic [1:0]      idx;
  logic            adv;
  logic            pop;
  logic            acc_r;
  logic            acc_l;
  logic            push_any;
  logic            drop;
  logic            q_empty;
  logic [CW-1:0]   q_count;
  vp_group_t       grp_r;
  vp_group_t       grp_l;
  vp_group_t       head;
  vp_entry_t       ent_p0;
  logic            fin_q;
  logic            fin_pend;
  logic            done_cond;

  always_comb begin
    for (int e = 0; e < VP_ENTRIES; e++) begin
      grp_r[e].addr = i_addr_right[e];
      grp_r[e].w    = i_w_right[e];
      grp_r[e].ia   = i_ia_right[e];
      grp_l[e].addr = i_addr_left[e];
      grp_l[e].w    = i_w_left[e];
      grp_l[e].ia   = i_ia_left[e];
    end
  end

  assign adv      = !o_valid || i_out_ready;
  assign pop      = (state == S_DRAIN) && adv && (idx == 2'd2);
  assign push_any = acc_r || acc_l;
  assign drop     = (i_right_ready && !acc_r) || (i_left_ready && !acc_l);
  assign ent_p0   = head[idx];

  vp_group_fifo #(.GRP_DEPTH(GRP_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push_r  (i_right_ready),
    .grp_r   (grp_r),
    .push_l  (i_left_ready),
    .grp_l   (grp_l),
    .pop     (pop),
    .head    (head),
    .acc_r   (acc_r),
    .acc_l   (acc_l),
    .empty   (q_empty),
    .count   (q_count)
  );

  // Stage p0 -> output register: entry select, multiply, skip zero-weight padding.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      idx     <= 2'd0;
      o_valid <= 1'b0;
      o_addr  <= '0;
      o_psum  <= '0;
    end else begin
      if (adv) o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (push_any) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (adv) begin
            if (ent_p0.w != '0) begin
              o_valid <= 1'b1;
              o_addr  <= ent_p0.addr;
              o_psum  <= mul_full(ent_p0.w, ent_p0.ia);
            end
            if (idx == 2'd2) begin
              idx <= 2'd0;
              // Last queued group just popped and nothing arriving behind it.
              if (q_count == CW'(1) && !push_any) state <= S_IDLE;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A group captured in the same cycle still counts as outstanding work.
  assign done_cond = fin_pend && q_empty && (state == S_IDLE) && adv && !push_any;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fin_q      <= 1'b0;
      fin_pend   <= 1'b0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      fin_q      <= i_finish;
      fin_pend   <= (i_finish && !fin_q) || (fin_pend && !done_cond);
      o_done     <= done_cond;
      o_overflow <= o_overflow || drop;
    end
  end

endmodule
